// File: rtl/whack_pkg.sv
// Shared definitions for the Whack-a-Mole round controller: state encoding,
// LFSR constants and the BCD digit limit.
package whack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_GAP       = 3'd2,
        ST_MOLE_UP   = 3'd3,
        ST_OVER      = 3'd4
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/whack_bcd2_counter.sv
// Two-digit BCD score counter: synchronous clear, single-step increment,
// holds at 99.
module whack_bcd2_counter
    import whack_pkg::*;
(
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] ones,
    output logic [3:0] tens
);

    logic at_max;
    assign at_max = (ones == BCD_MAX) && (tens == BCD_MAX);

    always_ff @(posedge ClockIn) begin
        if (Reset || clear) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else if (inc && !at_max) begin
            if (ones == BCD_MAX) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/whack_game_controller.sv
// Whack-a-Mole round sequencer: countdown, pseudo-random mole scheduling,
// hit/miss accounting and end-of-round handling on timer expiry.
module whack_game_controller
    import whack_pkg::*;
#(
    parameter int NUM_MOLES        = 4,
    parameter int COUNTDOWN_CYCLES = 150000000,
    parameter int GAP_CYCLES       = 12500000,
    parameter int HOLD_CYCLES      = 37500000,
    parameter int CNT_W            = 28
) (
    input  logic                 ClockIn,
    input  logic                 Reset,
    input  logic                 start_btn,
    input  logic [NUM_MOLES-1:0] hit_btn,
    input  logic                 timer_expired,
    output logic                 game_start,
    output logic                 game_done,
    output logic [NUM_MOLES-1:0] mole_led,
    output logic [3:0]           score_ones,
    output logic [3:0]           score_tens,
    output logic [3:0]           miss_count,
    output logic [2:0]           state_o
);

    localparam logic [CNT_W-1:0] LOAD_CD   = CNT_W'(COUNTDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_GAP  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_HOLD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]       MOLES     = 4'(NUM_MOLES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       lfsr;
    logic [2:0]       prev_idx;
    logic [3:0]       cand;
    logic [3:0]       idx;
    logic             hit;
    logic             score_clr;
    logic             score_inc;

    assign state_o = state;

    always_ff @(posedge ClockIn) begin
        if (Reset) lfsr <= LFSR_SEED;
        else       lfsr <= lfsr_next(lfsr);
    end

    // Never pick the same mole twice in a row: bump a repeat to its neighbour.
    always_comb begin
        cand = {1'b0, lfsr[2:0]} % MOLES;
        idx  = cand;
        if (cand[2:0] == prev_idx) idx = (cand + 4'd1) % MOLES;
    end

    // mole_led is one-hot on the active mole while MOLE_UP, so this masks
    // out presses on any other button.
    assign hit       = |(hit_btn & mole_led);
    assign score_inc = (state == ST_MOLE_UP) && !timer_expired && hit;
    assign score_clr = start_btn && ((state == ST_IDLE) || (state == ST_OVER));

    whack_bcd2_counter u_score (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .clear   (score_clr),
        .inc     (score_inc),
        .ones    (score_ones),
        .tens    (score_tens)
    );

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            prev_idx   <= 3'd0;
            mole_led   <= '0;
            miss_count <= 4'd0;
            game_start <= 1'b0;
            game_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_btn) begin
                        state      <= ST_COUNTDOWN;
                        cnt        <= LOAD_CD;
                        miss_count <= 4'd0;
                        game_done  <= 1'b0;
                    end
                end
                ST_COUNTDOWN, ST_GAP, ST_MOLE_UP: begin
                    if (timer_expired) begin
                        state      <= ST_OVER;
                        mole_led   <= '0;
                        game_start <= 1'b0;
                        game_done  <= 1'b1;
                    end else if (state == ST_MOLE_UP && hit) begin
                        state    <= ST_GAP;
                        cnt      <= LOAD_GAP;
                        mole_led <= '0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (state == ST_COUNTDOWN) begin
                        state      <= ST_GAP;
                        cnt        <= LOAD_GAP;
                        game_start <= 1'b1;
                    end else if (state == ST_GAP) begin
                        state    <= ST_MOLE_UP;
                        cnt      <= LOAD_HOLD;
                        mole_led <= NUM_MOLES'(1) << idx;
                        prev_idx <= idx[2:0];
                    end else begin
                        state    <= ST_GAP;
                        cnt      <= LOAD_GAP;
                        mole_led <= '0;
                        if (miss_count != 4'hF) miss_count <= miss_count + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_whack_game_controller.sv
// Directed and randomized checks of whack_game_controller against a
// cycle-level behavioural model of the round rules.
module tb_whack_game_controller;

    localparam int NM   = 4;
    localparam int CD   = 4;
    localparam int GAP  = 2;
    localparam int HOLD = 5;

    logic          ClockIn;
    logic          Reset;
    logic          start_btn;
    logic [NM-1:0] hit_btn;
    logic          timer_expired;
    logic          game_start;
    logic          game_done;
    logic [NM-1:0] mole_led;
    logic [3:0]    score_ones;
    logic [3:0]    score_tens;
    logic [3:0]    miss_count;
    logic [2:0]    state_o;

    whack_game_controller #(
        .NUM_MOLES(NM), .COUNTDOWN_CYCLES(CD), .GAP_CYCLES(GAP),
        .HOLD_CYCLES(HOLD), .CNT_W(8)
    ) dut (
        .ClockIn(ClockIn), .Reset(Reset), .start_btn(start_btn),
        .hit_btn(hit_btn), .timer_expired(timer_expired),
        .game_start(game_start), .game_done(game_done), .mole_led(mole_led),
        .score_ones(score_ones), .score_tens(score_tens),
        .miss_count(miss_count), .state_o(state_o)
    );

    initial ClockIn = 1'b0;
    always #5 ClockIn = ~ClockIn;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 countdown, 2 gap, 3 mole up, 4 over.
    // m_left is the number of cycles still to spend in the timed phase.
    int m_st, m_left, m_score, m_miss, m_lit, m_prev, m_lfsr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic [3:0] h, input logic te);
        int cand, fb;
        if (r) begin
            m_st = 0; m_left = 0; m_score = 0; m_miss = 0;
            m_lit = -1; m_prev = 0; m_lfsr = 'hA5;
            return;
        end
        case (m_st)
            0, 4: if (s) begin
                m_st = 1; m_left = CD; m_score = 0; m_miss = 0; m_lit = -1;
            end
            1: if (te) begin m_st = 4; m_lit = -1; end
               else if (m_left == 1) begin m_st = 2; m_left = GAP; end
               else m_left--;
            2: if (te) begin m_st = 4; m_lit = -1; end
               else if (m_left == 1) begin
                   cand = (m_lfsr % 8) % NM;
                   if (cand == m_prev) cand = (cand + 1) % NM;
                   m_prev = cand; m_lit = cand; m_st = 3; m_left = HOLD;
               end else m_left--;
            3: if (te) begin m_st = 4; m_lit = -1; end
               else if (h[m_lit]) begin
                   if (m_score < 99) m_score++;
                   m_lit = -1; m_st = 2; m_left = GAP;
               end else if (m_left == 1) begin
                   if (m_miss < 15) m_miss++;
                   m_lit = -1; m_st = 2; m_left = GAP;
               end else m_left--;
            default: m_st = 0;
        endcase
        fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 255;
    endtask

    function automatic logic [31:0] exp_vec();
        logic [3:0] led;
        led = (m_lit < 0) ? 4'd0 : 4'(1 << m_lit);
        return {11'd0, 3'(m_st), 1'(m_st == 2 || m_st == 3), 1'(m_st == 4), led,
                4'(m_score / 10), 4'(m_score % 10), 4'(m_miss)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {11'd0, state_o, game_start, game_done, mole_led, score_tens, score_ones, miss_count};
    endfunction

    task automatic cycle(input logic s, input logic [3:0] h, input logic te);
        start_btn = s; hit_btn = h; timer_expired = te;
        @(posedge ClockIn);
        model_step(Reset, s, h, te);
        #1;
        chk("cycle_outputs", dut_vec(), exp_vec());
        start_btn = 1'b0; hit_btn = '0; timer_expired = 1'b0;
    endtask

    task automatic wait_lit();
        for (int k = 0; k < 20; k++) begin
            if (m_st == 3) return;
            cycle(1'b0, 4'd0, 1'b0);
        end
        checks++; errors++;
        $error("FAIL wait_lit_timeout observed=state%0d expected=state3", m_st);
    endtask

    function automatic int led_index(input logic [3:0] led);
        for (int b = 0; b < NM; b++) if (led[b]) return b;
        return -1;
    endfunction

    int cnt_len, prev_seen, cur, run_len, seen, sc0, miss0;
    logic rs, rstart, rte;
    logic [3:0] rh;

    initial begin
        Reset = 1'b1; start_btn = 1'b0; hit_btn = '0; timer_expired = 1'b0;
        m_st = 0; m_left = 0; m_score = 0; m_miss = 0; m_lit = -1; m_prev = 0; m_lfsr = 'hA5;
        repeat (3) cycle(1'b0, 4'd0, 1'b0);
        chk("reset_state", dut_vec(), 32'd0);
        Reset = 1'b0;

        // timer_expired and hits are ignored while idle
        cycle(1'b0, 4'hF, 1'b1);
        cycle(1'b0, 4'd0, 1'b1);
        chk("idle_ignores_expiry", state_o, 3'd0);

        // start: game_start after 4+1 cycles, first mole 2 cycles later
        cnt_len = 1;
        cycle(1'b1, 4'd0, 1'b0);
        chk("countdown_entry", state_o, 3'd1);
        for (int k = 0; k < 20 && !game_start; k++) begin cnt_len++; cycle(1'b0, 4'd0, 1'b0); end
        chk("game_start_latency", cnt_len, CD + 1);
        cnt_len = 0;
        for (int k = 0; k < 20 && mole_led == '0; k++) begin cnt_len++; cycle(1'b0, 4'd0, 1'b0); end
        chk("first_mole_latency", cnt_len, GAP);
        chk("first_mole_onehot", $countones(mole_led), 1);

        // three unhit moles, each lit HOLD cycles, no repeats
        prev_seen = led_index(mole_led); run_len = 1; seen = 0;
        for (int k = 0; k < 80 && seen < 3; k++) begin
            cycle(1'b0, 4'd0, 1'b0);
            if (mole_led != '0) begin
                if (run_len == 0) begin
                    chk("mole_onehot", $countones(mole_led), 1);
                    cur = led_index(mole_led);
                    chk("mole_no_repeat", 32'(cur != prev_seen), 1);
                    prev_seen = cur;
                end
                run_len++;
            end else if (run_len != 0) begin
                chk("mole_hold_len", run_len, HOLD);
                seen++; run_len = 0;
            end
        end
        chk("miss_after_3", miss_count, 4'd3);
        chk("score_after_3", {score_tens, score_ones}, 8'h00);

        // correct hit scores next cycle and GAP lasts GAP cycles
        wait_lit();
        sc0 = m_score;
        cycle(1'b0, 4'(1 << m_lit), 1'b0);
        chk("hit_score_ones", score_ones, 4'((sc0 + 1) % 10));
        chk("hit_led_off", mole_led, 4'd0);
        cnt_len = 0;
        for (int k = 0; k < 10 && mole_led == '0; k++) begin cnt_len++; cycle(1'b0, 4'd0, 1'b0); end
        chk("gap_len_after_hit", cnt_len, GAP);

        // wrong-bit press: ignored, mole times out as a miss
        sc0 = m_score; miss0 = m_miss; run_len = 1;
        cycle(1'b0, 4'(1 << ((m_lit + 1) % NM)), 1'b0);
        chk("wrong_no_score", {score_tens, score_ones}, 8'h01);
        for (int k = 0; k < 10 && mole_led != '0; k++) begin run_len++; cycle(1'b0, 4'd0, 1'b0); end
        chk("wrong_hold_len", run_len, HOLD);
        chk("wrong_miss_inc", miss_count, 4'(miss0 + 1));

        // 100 hits: BCD rollover then saturation at 99
        for (int i = 0; i < 100; i++) begin
            wait_lit();
            cycle(1'b0, 4'(1 << m_lit), 1'b0);
        end
        chk("score_saturated", {score_tens, score_ones}, 8'h99);

        // hit coinciding with expiry is not scored
        wait_lit();
        cycle(1'b0, 4'(1 << m_lit), 1'b1);
        chk("expiry_state", state_o, 3'd4);
        chk("expiry_score_frozen", {score_tens, score_ones}, 8'h99);
        chk("expiry_game_done", {game_done, game_start, mole_led}, 6'b100000);
        cycle(1'b0, 4'd0, 1'b1);
        chk("over_ignores_expiry", state_o, 3'd4);
        cycle(1'b1, 4'd0, 1'b0);
        chk("restart_state", state_o, 3'd1);
        chk("restart_cleared", {score_tens, score_ones, miss_count}, 12'h000);

        // reset in the middle of MOLE_UP
        wait_lit();
        cycle(1'b0, 4'd0, 1'b0);
        Reset = 1'b1;
        cycle(1'b0, 4'hF, 1'b1);
        chk("midgame_reset", dut_vec(), 32'd0);
        Reset = 1'b0;

        // randomized play
        for (int i = 0; i < 1500; i++) begin
            rs = ($urandom % 300) == 0;
            rstart = ($urandom % 12) == 0;
            rte = ($urandom % 50) == 0;
            if ($urandom % 5 == 0) rh = 4'($urandom);
            else if (m_st == 3 && ($urandom % 3) == 0) rh = 4'(1 << m_lit);
            else rh = 4'd0;
            Reset = rs;
            cycle(rstart, rh, rte);
            Reset = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/whack_game_controller.md
Name: whack_game_controller

Overview:
Top-level sequencer for a Whack-a-Mole round. It runs the pre-game countdown, drives game_start and game_done to the game timer, and schedules moles pseudo-randomly onto one-hot LEDs. It detects hits from pulsed buttons, keeps a two-digit BCD score and a miss count, and ends the round on the timer's expiry signal.

Parameters:
NUM_MOLES, 4, number of mole LEDs/buttons; legal range 2..8
COUNTDOWN_CYCLES, 150000000, ClockIn cycles from start press to first gap (3 s at 50 MHz)
GAP_CYCLES, 12500000, cycles with no mole lit between moles
HOLD_CYCLES, 37500000, cycles a mole stays lit before counting as a miss
CNT_W, 28, width of the shared down-counter; must hold the largest of the three cycle parameters

Ports:
ClockIn  in  1  system clock
Reset  in  1  synchronous, active-high reset
start_btn  in  1  single-cycle start pulse, already debounced
hit_btn  in  NUM_MOLES  single-cycle hit pulses, one bit per mole, already debounced
timer_expired  in  1  round-time-over level from the game timer
game_start  out  1  high while the round is live (GAP and MOLE_UP states)
game_done  out  1  high in OVER state
mole_led  out  NUM_MOLES  one-hot lit mole; zero when no mole is up
score_ones  out  4  BCD ones digit of the score
score_tens  out  4  BCD tens digit of the score
miss_count  out  4  binary count of missed moles, saturates at 15
state_o  out  3  current FSM state, for debug

Behaviour:
- Reset value of every output and register: state IDLE, mole_led 0, score 00, miss_count 0, game_start 0, game_done 0, counter 0, prev_idx 0, LFSR 8'hA5. Reset wins over every other input.
- The LFSR is 8 bits, Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every non-reset cycle and never reaches zero.
- The counter is a single down-counter shared by all timed states; it is loaded with N-1 on state entry, so each timed state lasts exactly N cycles.
- All outputs are registered: they change one cycle after the triggering edge.
- IDLE: outputs quiet. start_btn -> COUNTDOWN; clear score and miss_count; load COUNTDOWN_CYCLES-1.
- COUNTDOWN: game_start stays 0. When the counter reaches 0 -> GAP; load GAP_CYCLES-1.
- GAP: mole_led 0, game_start 1. When the counter reaches 0 -> MOLE_UP.
- Mole selection on the GAP->MOLE_UP transition:
  - cand = LFSR[2:0] mod NUM_MOLES.
  - If cand == prev_idx, idx = (cand+1) mod NUM_MOLES; otherwise idx = cand.
  - mole_led = 1<<idx; prev_idx <= idx; load HOLD_CYCLES-1.
- MOLE_UP, per cycle, in priority order:
  1. timer_expired -> OVER.
  2. hit_btn[idx] -> score += 1 (BCD), mole_led 0, -> GAP, load GAP_CYCLES-1. This applies even if other hit bits are also set.
  3. Counter reaches 0 -> miss_count += 1 (saturating), -> GAP.
  - hit_btn bits other than idx are ignored.
- BCD score: ones 9 -> 0 with carry into tens. The score saturates at 99, and a further hit leaves it at 99.
- timer_expired high in COUNTDOWN, GAP or MOLE_UP -> OVER on the next edge. A hit in that same cycle is not scored.
- OVER: game_done 1, game_start 0, mole_led 0; score and miss_count frozen. start_btn -> COUNTDOWN with score and miss_count cleared.
- timer_expired is ignored in IDLE and OVER.
- start_btn is ignored in COUNTDOWN, GAP and MOLE_UP.
- Reset in any state returns to IDLE on the next edge and clears the score.

Decomposition:
- Package whack_pkg holds:
  - state encoding: IDLE=0, COUNTDOWN=1, GAP=2, MOLE_UP=3, OVER=4
  - LFSR_SEED = 8'hA5
  - LFSR tap constant
  - BCD_MAX digit = 9
- One sub-module, whack_bcd2_counter: two-digit saturating BCD incrementer with clear and inc inputs.
- The LFSR and the FSM live inline in the top module.

Test Plan:
Common parameters: NUM_MOLES=4, COUNTDOWN_CYCLES=4, GAP_CYCLES=2, HOLD_CYCLES=5.
- Reset then start_btn pulse -> game_start rises 4+1 cycles after the pulse, first mole_led lights 2 cycles later, and mole_led is one-hot.
- No hits for 3 moles -> each mole is lit exactly 5 cycles, miss_count=3, score 00, and consecutive moles never share an index.
- Correct hit_btn pulse on the lit bit in the hold window -> score_ones increments next cycle, mole_led 0, GAP lasts 2 cycles.
- Wrong-bit hit_btn pulse -> no score change, mole stays lit until timeout, then miss_count increments.
- 100 correct hits -> digits roll 09->10 correctly; the score stops at tens=9, ones=9.
- Correct hit and timer_expired in the same cycle -> state OVER, score unchanged, game_done=1. A following start_btn -> COUNTDOWN with score 00 and miss 0. Reset asserted mid MOLE_UP -> IDLE with all outputs 0.
